// File: rtl/icache_sa_burst.sv
// Set-associative instruction cache with burst line refill, critical-word capture,
// uncached bypass and whole-cache invalidate; one outstanding fetch at a time.
module icache_sa_burst #(
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 64,
  parameter int WAYS       = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] s_araddr,
  input  logic        s_uncached,
  input  logic        s_arvalid,
  output logic        s_arready,
  output logic [31:0] s_rdata,
  output logic        s_rvalid,
  input  logic        s_rready,
  input  logic        s_inval,
  output logic [31:0] m_araddr,
  output logic [3:0]  m_arlen,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic        m_rvalid,
  input  logic        m_rlast,
  output logic        m_rready
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam logic [3:0] CACHED_LEN = 4'(LINE_WORDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MISS_AR, S_REFILL, S_RESP} state_t;
  state_t r_state, w_next;

  logic [31:0]      r_addr;
  logic             r_unc;
  logic             r_victim;
  logic             r_inval_pend;
  logic [OFF_W-1:0] r_beat;
  logic [SETS-1:0]  r_valid [WAYS];
  logic [SETS-1:0]  r_lru;
  logic [TAG_W-1:0] r_tag   [WAYS][SETS];
  logic [31:0]      r_data  [WAYS][SETS][LINE_WORDS];

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [OFF_W-1:0] w_off;
  logic             w_hit, w_hit_way, w_victim;
  logic             w_beat_fire, w_refill_done, w_alloc, w_clear;
  logic             w_unused;

  assign w_idx    = r_addr[OFF_W+2 +: IDX_W];
  assign w_tag    = r_addr[31 -: TAG_W];
  assign w_off    = r_addr[2 +: OFF_W];
  assign w_unused = ^r_addr[1:0];

  // Tag compare and victim choice read the register arrays combinationally during LOOKUP.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag)) begin
        w_hit     = !r_unc;
        w_hit_way = 1'(w);
      end
    end
    w_victim = (WAYS > 1) ? r_lru[w_idx] : 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w][w_idx]) w_victim = 1'(w);
    end
  end

  assign w_beat_fire   = (r_state == S_REFILL) && m_rvalid;
  assign w_refill_done = w_beat_fire && (m_rlast || r_unc);
  assign w_alloc       = w_refill_done && !r_unc;
  assign w_clear       = (r_state == S_IDLE) && (s_inval || r_inval_pend);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (s_arvalid)     w_next = S_LOOKUP;
      S_LOOKUP:  w_next = w_hit ? S_RESP : S_MISS_AR;
      S_MISS_AR: if (m_arready)     w_next = S_REFILL;
      S_REFILL:  if (w_refill_done) w_next = S_RESP;
      S_RESP:    if (s_rready)      w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    s_arready = (r_state == S_IDLE);
    m_arvalid = (r_state == S_MISS_AR);
    m_rready  = (r_state == S_REFILL);
    s_rvalid  = (r_state == S_RESP);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr       <= '0;
      r_unc        <= 1'b0;
      r_victim     <= 1'b0;
      r_beat       <= '0;
      r_inval_pend <= 1'b0;
      r_lru        <= '0;
      m_araddr     <= '0;
      m_arlen      <= '0;
      s_rdata      <= '0;
      for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
    end else begin
      if (s_arready && s_arvalid) begin
        r_addr <= s_araddr;
        r_unc  <= s_uncached;
      end
      if (r_state == S_LOOKUP) begin
        if (w_hit) begin
          s_rdata <= r_data[w_hit_way][w_idx][w_off];
          if (WAYS > 1) r_lru[w_idx] <= ~w_hit_way;
        end else begin
          m_araddr <= r_unc ? {r_addr[31:2], 2'b00}
                            : {r_addr[31:OFF_W+2], {(OFF_W+2){1'b0}}};
          m_arlen  <= r_unc ? 4'd0 : CACHED_LEN;
          r_victim <= w_victim;
          r_beat   <= '0;
        end
      end
      // Counter only indexes words; m_rlast decides when the burst ends.
      if (w_beat_fire) begin
        r_beat <= r_beat + OFF_W'(1);
        if (r_unc || (r_beat == w_off)) s_rdata <= m_rdata;
      end
      if (w_alloc && (WAYS > 1)) r_lru[w_idx] <= ~r_victim;
      if (r_state == S_IDLE) r_inval_pend <= 1'b0;
      else if (s_inval)      r_inval_pend <= 1'b1;
      if (w_clear) begin
        for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
      end else if (w_alloc) begin
        r_valid[r_victim][w_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_beat_fire && !r_unc) r_data[r_victim][w_idx][r_beat] <= m_rdata;
    if (w_alloc)               r_tag[r_victim][w_idx]          <= w_tag;
  end

endmodule

// File: tb/tb_icache_sa_burst.sv
// Bench for icache_sa_burst: randomised bridge timing, memory-backed data and a
// recency-ordered per-set tag model predicting hits, misses and refill requests.
module tb_icache_sa_burst;
  localparam int LW   = 4;
  localparam int SETS = 64;
  localparam int WAYS = 2;
  localparam int OFFB = 4;
  localparam int IDXB = 6;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] s_araddr = '0;
  logic        s_uncached = 1'b0, s_arvalid = 1'b0, s_rready = 1'b0, s_inval = 1'b0;
  logic        s_arready, s_rvalid, m_arvalid, m_rready;
  logic [31:0] s_rdata, m_araddr;
  logic [3:0]  m_arlen;
  logic        m_arready = 1'b0, m_rvalid = 1'b0, m_rlast = 1'b0;
  logic [31:0] m_rdata = '0;

  int errors = 0, checks = 0, cyc = 0, ar_count = 0;
  logic [31:0] br_addr = '0;
  logic [3:0]  br_len = '0;
  logic [31:0] salt;
  logic [31:0] model_set [SETS][$];

  icache_sa_burst #(.LINE_WORDS(LW), .SETS(SETS), .WAYS(WAYS)) dut (
    .clk(clk), .resetn(resetn),
    .s_araddr(s_araddr), .s_uncached(s_uncached), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rready(s_rready), .s_inval(s_inval),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rready(m_rready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'h9E37_79B1) ^ salt ^ {w[15:0], w[31:16]};
  endfunction

  function automatic int set_of(input logic [31:0] a);
    return int'((a >> OFFB) & 32'(SETS - 1));
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    int s = set_of(a);
    for (int i = 0; i < model_set[s].size(); i++)
      if (model_set[s][i] == (a >> (OFFB + IDXB))) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_touch(input logic [31:0] a);
    int s = set_of(a);
    logic [31:0] t = a >> (OFFB + IDXB);
    for (int i = 0; i < model_set[s].size(); i++)
      if (model_set[s][i] == t) begin
        model_set[s].delete(i);
        break;
      end
    model_set[s].push_front(t);
    if (model_set[s].size() > WAYS) void'(model_set[s].pop_back());
  endtask

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) model_set[s].delete();
  endtask

  function automatic logic [31:0] exp_araddr(input logic [31:0] a, input bit unc);
    return unc ? {a[31:2], 2'b00} : (a & ~32'(LW * 4 - 1));
  endfunction

  // Read bridge: random accept delay and random gaps between beats.
  initial begin
    forever begin
      @(negedge clk);
      if (m_arvalid && resetn) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        br_addr   = m_araddr;
        br_len    = m_arlen;
        m_arready = 1'b1;
        @(negedge clk);
        m_arready = 1'b0;
        ar_count++;
        for (int b = 0; b <= int'(br_len); b++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          m_rvalid = 1'b1;
          m_rdata  = mem_word(br_addr + 32'(4 * b));
          m_rlast  = (b == int'(br_len));
          @(negedge clk);
          m_rvalid = 1'b0;
          m_rlast  = 1'b0;
        end
      end
    end
  end

  task automatic fetch(input logic [31:0] addr, input bit unc, input bit inval_same,
                       input bit inval_mid, input int stall,
                       output logic [31:0] data, output bit missed, output int lat,
                       output logic [31:0] araddr, output logic [3:0] arlen,
                       output bit stable, output bit arrdy_low, output bit one_pulse,
                       output bit tmo);
    int c0, n0, n;
    bit inval_done;
    tmo = 1'b0; stable = 1'b1; arrdy_low = 1'b1; one_pulse = 1'b1; inval_done = 1'b0;
    @(negedge clk); #1;
    s_araddr = addr; s_uncached = unc; s_arvalid = 1'b1; s_inval = inval_same;
    n = 0;
    while (!s_arready && n < 50) begin @(negedge clk); #1; n++; end
    c0 = cyc; n0 = ar_count;
    @(negedge clk); #1;
    s_arvalid = 1'b0; s_inval = 1'b0;
    n = 0;
    while (!s_rvalid && n < 200) begin
      if (s_arready) arrdy_low = 1'b0;
      if (inval_mid && !inval_done && ar_count != n0) begin
        s_inval = 1'b1; inval_done = 1'b1;
      end else s_inval = 1'b0;
      @(negedge clk); #1; n++;
    end
    s_inval = 1'b0;
    tmo = !s_rvalid;
    lat = cyc - c0;
    missed = (ar_count != n0);
    araddr = br_addr; arlen = br_len; data = s_rdata;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk); #1;
      if (!s_rvalid || s_rdata !== data) stable = 1'b0;
      if (s_arready) arrdy_low = 1'b0;
    end
    s_rready = 1'b1;
    @(negedge clk); #1;
    s_rready = 1'b0;
    if (s_rvalid) one_pulse = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk); #1;
    checks++; if (s_arready !== 1'b1) begin errors++; $display("FAIL reset.s_arready got=%b exp=1", s_arready); end
    checks++; if (s_rvalid !== 1'b0) begin errors++; $display("FAIL reset.s_rvalid got=%b exp=0", s_rvalid); end
    checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL reset.m_arvalid got=%b exp=0", m_arvalid); end
    checks++; if (m_rready !== 1'b0) begin errors++; $display("FAIL reset.m_rready got=%b exp=0", m_rready); end
    checks++; if (m_araddr !== 32'h0) begin errors++; $display("FAIL reset.m_araddr got=%h exp=0", m_araddr); end
    checks++; if (m_arlen !== 4'h0) begin errors++; $display("FAIL reset.m_arlen got=%h exp=0", m_arlen); end
    checks++; if (s_rdata !== 32'h0) begin errors++; $display("FAIL reset.s_rdata got=%h exp=0", s_rdata); end
    model_clear();
  endtask

  task automatic test_cold_miss();
    logic [31:0] d, aa; logic [3:0] al; bit ms, st, lo, op, to; int lt;
    fetch(32'h1FC0_0008, 0, 0, 0, 0, d, ms, lt, aa, al, st, lo, op, to);
    checks++; if (to) begin errors++; $display("FAIL cold.timeout got=no_rvalid exp=rvalid"); end
    checks++; if (ms !== 1'b1) begin errors++; $display("FAIL cold.miss got=%b exp=1", ms); end
    checks++; if (aa !== 32'h1FC0_0000) begin errors++; $display("FAIL cold.araddr got=%h exp=1fc00000", aa); end
    checks++; if (al !== 4'd3) begin errors++; $display("FAIL cold.arlen got=%0d exp=3", al); end
    checks++; if (d !== mem_word(32'h1FC0_0008)) begin errors++; $display("FAIL cold.data got=%h exp=%h", d, mem_word(32'h1FC0_0008)); end
    checks++; if (!op) begin errors++; $display("FAIL cold.one_rvalid got=extra exp=single"); end
    checks++; if (!lo) begin errors++; $display("FAIL cold.arready_busy got=1 exp=0"); end
    model_touch(32'h1FC0_0008);
  endtask

  task automatic test_rehit();
    logic [31:0] d, aa; logic [3:0] al; bit ms, st, lo, op, to; int lt;
    fetch(32'h1FC0_000C, 0, 0, 0, 0, d, ms, lt, aa, al, st, lo, op, to);
    checks++; if (to) begin errors++; $display("FAIL rehit.timeout got=no_rvalid exp=rvalid"); end
    checks++; if (ms !== 1'b0) begin errors++; $display("FAIL rehit.miss got=%b exp=0", ms); end
    checks++; if (lt != 2) begin errors++; $display("FAIL rehit.latency got=%0d exp=2", lt); end
    checks++; if (d !== mem_word(32'h1FC0_000C)) begin errors++; $display("FAIL rehit.data got=%h exp=%h", d, mem_word(32'h1FC0_000C)); end
    model_touch(32'h1FC0_000C);
  endtask

  task automatic test_conflict();
    logic [31:0] d, aa; logic [3:0] al; bit ms, st, lo, op, to; int lt;
    logic [31:0] seq [6];
    bit          exp_miss [6];
    seq = '{32'h0001_0024, 32'h0002_0028, 32'h0001_002C, 32'h0003_0020, 32'h0001_0020, 32'h0002_0024};
    exp_miss = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      fetch(seq[i], 0, 0, 0, 0, d, ms, lt, aa, al, st, lo, op, to);
      checks++; if (ms !== exp_miss[i]) begin errors++; $display("FAIL conflict.miss[%0d] got=%b exp=%b", i, ms, exp_miss[i]); end
      checks++; if (d !== mem_word(seq[i])) begin errors++; $display("FAIL conflict.data[%0d] got=%h exp=%h", i, d, mem_word(seq[i])); end
      model_touch(seq[i]);
    end
  endtask

  task automatic test_uncached();
    logic [31:0] d, aa; logic [3:0] al; bit ms, st, lo, op, to; int lt;
    for (int r = 0; r < 2; r++) begin
      fetch(32'hBFC0_0000, 1, 0, 0, 0, d, ms, lt, aa, al, st, lo, op, to);
      checks++; if (ms !== 1'b1) begin errors++; $display("FAIL uncached.miss[%0d] got=%b exp=1", r, ms); end
      checks++; if (al !== 4'd0) begin errors++; $display("FAIL uncached.arlen[%0d] got=%0d exp=0", r, al); end
      checks++; if (aa !== 32'hBFC0_0000) begin errors++; $display("FAIL uncached.araddr[%0d] got=%h exp=bfc00000", r, aa); end
      checks++; if (d !== mem_word(32'hBFC0_0000)) begin errors++; $display("FAIL uncached.data[%0d] got=%h exp=%h", r, d, mem_word(32'hBFC0_0000)); end
    end
  endtask

  task automatic test_inval_midrefill();
    logic [31:0] d, aa; logic [3:0] al; bit ms, st, lo, op, to; int lt;
    fetch(32'h0004_0044, 0, 0, 1, 0, d, ms, lt, aa, al, st, lo, op, to);
    checks++; if (ms !== 1'b1) begin errors++; $display("FAIL inval_mid.miss got=%b exp=1", ms); end
    checks++; if (d !== mem_word(32'h0004_0044)) begin errors++; $display("FAIL inval_mid.data got=%h exp=%h", d, mem_word(32'h0004_0044)); end
    model_touch(32'h0004_0044);
    model_clear();
    fetch(32'h0004_0048, 0, 0, 0, 0, d, ms, lt, aa, al, st, lo, op, to);
    checks++; if (ms !== 1'b1) begin errors++; $display("FAIL inval_mid.refetch_miss got=%b exp=1", ms); end
    checks++; if (d !== mem_word(32'h0004_0048)) begin errors++; $display("FAIL inval_mid.refetch_data got=%h exp=%h", d, mem_word(32'h0004_0048)); end
    model_touch(32'h0004_0048);
  endtask

  task automatic test_inval_same();
    logic [31:0] d, aa; logic [3:0] al; bit ms, st, lo, op, to; int lt;
    fetch(32'h0004_0040, 0, 0, 0, 0, d, ms, lt, aa, al, st, lo, op, to);
    checks++; if (ms !== 1'b0) begin errors++; $display("FAIL inval_same.prehit got=%b exp=0", ms); end
    model_clear();
    fetch(32'h0004_0040, 0, 1, 0, 0, d, ms, lt, aa, al, st, lo, op, to);
    checks++; if (ms !== 1'b1) begin errors++; $display("FAIL inval_same.miss got=%b exp=1", ms); end
    checks++; if (d !== mem_word(32'h0004_0040)) begin errors++; $display("FAIL inval_same.data got=%h exp=%h", d, mem_word(32'h0004_0040)); end
    model_touch(32'h0004_0040);
  endtask

  task automatic test_rready_stall();
    logic [31:0] d, aa; logic [3:0] al; bit ms, st, lo, op, to, em; int lt;
    em = !model_hit(32'h1FC0_0004);
    fetch(32'h1FC0_0004, 0, 0, 0, 5, d, ms, lt, aa, al, st, lo, op, to);
    checks++; if (ms !== em) begin errors++; $display("FAIL stall.miss got=%b exp=%b", ms, em); end
    checks++; if (!st) begin errors++; $display("FAIL stall.stable got=changed exp=held"); end
    checks++; if (!lo) begin errors++; $display("FAIL stall.arready got=1 exp=0"); end
    checks++; if (d !== mem_word(32'h1FC0_0004)) begin errors++; $display("FAIL stall.data got=%h exp=%h", d, mem_word(32'h1FC0_0004)); end
    checks++; if (!op) begin errors++; $display("FAIL stall.release got=rvalid exp=idle"); end
    model_touch(32'h1FC0_0004);
  endtask

  task automatic test_random();
    logic [31:0] d, aa, a; logic [3:0] al; bit ms, st, lo, op, to, unc, isame, imid, em; int lt;
    for (int it = 0; it < 60; it++) begin
      a = 32'h2000_0000 | (32'($urandom_range(0, 3)) << (OFFB + IDXB))
        | (32'($urandom_range(0, 3)) << OFFB) | 32'($urandom_range(0, 15));
      unc   = ($urandom_range(0, 7) == 0);
      isame = ($urandom_range(0, 15) == 0);
      if (isame) model_clear();
      em   = unc || !model_hit(a);
      imid = em && ($urandom_range(0, 9) == 0);
      fetch(a, unc, isame, imid, int'($urandom_range(0, 2)), d, ms, lt, aa, al, st, lo, op, to);
      checks++; if (to) begin errors++; $display("FAIL rand[%0d].timeout got=no_rvalid exp=rvalid", it); end
      checks++; if (ms !== em) begin errors++; $display("FAIL rand[%0d].miss addr=%h got=%b exp=%b", it, a, ms, em); end
      checks++; if (d !== mem_word(a)) begin errors++; $display("FAIL rand[%0d].data addr=%h got=%h exp=%h", it, a, d, mem_word(a)); end
      if (em) begin
        checks++; if (aa !== exp_araddr(a, unc)) begin errors++; $display("FAIL rand[%0d].araddr got=%h exp=%h", it, aa, exp_araddr(a, unc)); end
        checks++; if (al !== (unc ? 4'd0 : 4'(LW - 1))) begin errors++; $display("FAIL rand[%0d].arlen got=%0d exp=%0d", it, al, unc ? 0 : LW - 1); end
      end else begin
        checks++; if (lt != 2) begin errors++; $display("FAIL rand[%0d].latency got=%0d exp=2", it, lt); end
      end
      if (!unc) model_touch(a);
      if (imid) model_clear();
    end
  endtask

  task automatic test_reset_clears();
    logic [31:0] d, aa; logic [3:0] al; bit ms, st, lo, op, to; int lt;
    fetch(32'h0005_0050, 0, 0, 0, 0, d, ms, lt, aa, al, st, lo, op, to);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk); #1;
    checks++; if (s_rdata !== 32'h0) begin errors++; $display("FAIL reset2.s_rdata got=%h exp=0", s_rdata); end
    resetn = 1'b1;
    model_clear();
    fetch(32'h0005_0050, 0, 0, 0, 0, d, ms, lt, aa, al, st, lo, op, to);
    checks++; if (ms !== 1'b1) begin errors++; $display("FAIL reset2.miss got=%b exp=1", ms); end
    checks++; if (d !== mem_word(32'h0005_0050)) begin errors++; $display("FAIL reset2.data got=%h exp=%h", d, mem_word(32'h0005_0050)); end
  endtask

  initial begin
    salt = $urandom;
    test_reset();
    test_cold_miss();
    test_rehit();
    test_conflict();
    test_uncached();
    test_inval_midrefill();
    test_inval_same();
    test_rready_stall();
    test_random();
    test_reset_clears();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
